mbm_frac_add_pipe: RTL and testbench

MBM_FRAC_ADD_PIPE -- requirements
Module: mbm_frac_add_pipe

---
 rtl/mbm_frac_add_pipe_if.sv | 30 +++
 rtl/mbm_frac_add_pipe.sv | 101 ++++++++++
 tb/tb_mbm_frac_add_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mbm_frac_add_pipe_if.sv
// Handshake bundle for the MBM fraction adder pipeline.
// master drives operands and out_ready; slave is the adder.
interface mbm_frac_add_pipe_if #(
  parameter int N  = 8,
  parameter int KW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-2:0]  x1;
  logic [N-2:0]  x2;
  logic [KW-1:0] k1;
  logic [KW-1:0] k2;
  logic          corr_en;
  logic          out_valid;
  logic          out_ready;
  logic          carry;
  logic [N-2:0]  fractional;
  logic [KW:0]   char_sum;
  logic [15:0]   sat_cnt;

  modport master (
    output in_valid, x1, x2, k1, k2, corr_en, out_ready,
    input  in_ready, out_valid, carry, fractional, char_sum, sat_cnt
  );

  modport slave (
    input  in_valid, x1, x2, k1, k2, corr_en, out_ready,
    output in_ready, out_valid, carry, fractional, char_sum, sat_cnt
  );
endinterface

// File: rtl/mbm_frac_add_pipe.sv
// Two-stage Mitchell log fraction adder with MBM correction.
// S1 adds operands, S2 applies carry/correction and drives outputs.
module mbm_frac_add_pipe #(
  parameter int N  = 8,
  parameter int L  = 3,
  parameter int KW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  mbm_frac_add_pipe_if.slave bus
);
  localparam logic [N-1:0] C = N'(1) << (N - 1 - L);

  logic          s1_valid;
  logic [N-1:0]  s1_s;
  logic [KW:0]   s1_k;
  logic          s1_corr;

  logic          s2_valid;
  logic          s2_carry;
  logic [N-2:0]  s2_frac;
  logic [KW:0]   s2_char;
  logic [15:0]   s2_sat;

  logic          s1_en;
  logic          s2_en;
  logic [N-1:0]  sum_in;
  logic [KW:0]   k_in;

  logic          carry_n;
  logic [N-1:0]  adj;
  logic          sat_n;
  logic [N-2:0]  frac_n;
  logic [KW:0]   char_n;

  assign s2_en  = !s2_valid || bus.out_ready;
  assign s1_en  = !s1_valid || s2_en;
  assign sum_in = {1'b0, bus.x1} + {1'b0, bus.x2};
  assign k_in   = {1'b0, bus.k1} + {1'b0, bus.k2};

  // Carry select, correction and saturation for the S1 beat.
  always_comb begin
    carry_n = s1_s[N-1];
    adj     = {1'b0, s1_s[N-2:0]} + C;
    sat_n   = 1'b0;
    frac_n  = s1_s[N-2:0];
    char_n  = s1_k + {{KW{1'b0}}, carry_n};
    if (!carry_n && s1_corr) begin
      if (adj[N-1]) begin
        sat_n  = 1'b1;
        frac_n = '1;
      end else begin
        frac_n = adj[N-2:0];
      end
    end
  end

  // S1: capture operand sums on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_k     <= '0;
      s1_corr  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_s    <= sum_in;
        s1_k    <= k_in;
        s1_corr <= bus.corr_en;
      end
    end
  end

  // S2: registered results and saturation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_carry <= 1'b0;
      s2_frac  <= '0;
      s2_char  <= '0;
      s2_sat   <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_carry <= carry_n;
        s2_frac  <= frac_n;
        s2_char  <= char_n;
        if (sat_n && s2_sat != 16'hFFFF)
          s2_sat <= s2_sat + 16'd1;
      end
    end
  end

  assign bus.in_ready   = s1_en;
  assign bus.out_valid  = s2_valid;
  assign bus.carry      = s2_carry;
  assign bus.fractional = s2_frac;
  assign bus.char_sum   = s2_char;
  assign bus.sat_cnt    = s2_sat;
endmodule

// File: tb/tb_mbm_frac_add_pipe.sv
// Directed-vector bench for mbm_frac_add_pipe (N=8, L=3, KW=3).
// Each task drives one scenario and checks results inline.
module tb_mbm_frac_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  mbm_frac_add_pipe_if #(.N(8), .KW(3)) bus ();

  mbm_frac_add_pipe #(.N(8), .L(3), .KW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] t_x1 [5] = '{7'h01, 7'h50, 7'h70, 7'h22, 7'h7F};
  logic [6:0] t_x2 [5] = '{7'h02, 7'h40, 7'h05, 7'h11, 7'h7F};
  logic [2:0] t_k1 [5] = '{3'd1, 3'd0, 3'd3, 3'd5, 3'd7};
  logic [2:0] t_k2 [5] = '{3'd2, 3'd0, 3'd4, 3'd5, 3'd7};
  logic       t_ce [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       e_c  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [6:0] e_f  [5] = '{7'h13, 7'h10, 7'h7F, 7'h33, 7'h7E};
  logic [3:0] e_k  [5] = '{4'd3, 4'd1, 4'd7, 4'd10, 4'd15};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] a, input logic [6:0] b,
                      input logic [2:0] ka, input logic [2:0] kb,
                      input logic ce);
    bus.x1       = a;
    bus.x2       = b;
    bus.k1       = ka;
    bus.k2       = kb;
    bus.corr_en  = ce;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x1 = '0; bus.x2 = '0; bus.k1 = '0; bus.k2 = '0;
    bus.corr_en = 1'b0;
    step();
    step();
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !== 13'd0)
      $display("FAIL reset_outs got %b/%b/%h/%h want 0/0/00/0",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    checks++;
    if (bus.sat_cnt !== 16'd0)
      $display("FAIL reset_sat got %h want 0000", bus.sat_cnt);
    else passed++;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_carry();
    send(7'h40, 7'h40, 3'd2, 3'd3, 1'b1);
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !==
        {1'b1, 1'b1, 7'h00, 4'd6})
      $display("FAIL carry got v%b c%b f%h k%0d want v1 c1 f00 k6",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    step();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL carry_drain got %b want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_corr();
    send(7'h10, 7'h20, 3'd1, 3'd1, 1'b1);
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !==
        {1'b1, 1'b0, 7'h40, 4'd2})
      $display("FAIL corr_on got v%b c%b f%h k%0d want v1 c0 f40 k2",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    send(7'h10, 7'h20, 3'd1, 3'd1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !==
        {1'b1, 1'b0, 7'h30, 4'd2})
      $display("FAIL corr_off got v%b c%b f%h k%0d want v1 c0 f30 k2",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
  endtask

  task automatic test_sat();
    checks++;
    if (bus.sat_cnt !== 16'd0)
      $display("FAIL sat_before got %0d want 0", bus.sat_cnt);
    else passed++;
    send(7'h3F, 7'h3F, 3'd0, 3'd0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !==
        {1'b1, 1'b0, 7'h7F, 4'd0})
      $display("FAIL sat_val got v%b c%b f%h k%0d want v1 c0 f7f k0",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    checks++;
    if (bus.sat_cnt !== 16'd1)
      $display("FAIL sat_cnt got %0d want 1", bus.sat_cnt);
    else passed++;
  endtask

  task automatic test_char_max();
    send(7'h40, 7'h40, 3'd7, 3'd7, 1'b1);
    checks++;
    if ({bus.carry, bus.fractional, bus.char_sum} !== {1'b1, 7'h00, 4'd15})
      $display("FAIL char_max got c%b f%h k%0d want c1 f00 k15",
               bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         got = 0;
    bit         dropped = 0;
    bit         held = 0;
    bit         bad_order = 0;
    bit         bad_hold = 0;
    logic [6:0] hf;
    logic       hc;
    logic [3:0] hk;
    for (int cyc = 1; cyc <= 30 && got < 5; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.x1      = t_x1[sent];
        bus.x2      = t_x2[sent];
        bus.k1      = t_k1[sent];
        bus.k2      = t_k2[sent];
        bus.corr_en = t_ce[sent];
      end
      #1;
      if (held) begin
        if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !==
            {1'b1, hc, hf, hk})
          bad_hold = 1;
        held = 0;
      end
      if (!bus.in_ready) dropped = 1;
      if (bus.out_valid && bus.out_ready) begin
        if ({bus.carry, bus.fractional, bus.char_sum} !==
            {e_c[got], e_f[got], e_k[got]}) begin
          bad_order = 1;
          $display("FAIL b2b_beat%0d got c%b f%h k%0d want c%b f%h k%0d",
                   got, bus.carry, bus.fractional, bus.char_sum,
                   e_c[got], e_f[got], e_k[got]);
        end
        got++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        held = 1;
        hc = bus.carry;
        hf = bus.fractional;
        hk = bus.char_sum;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bad_order) $display("FAIL b2b_order got mismatch want in-order beats");
    else passed++;
    checks++;
    if (got !== 5) $display("FAIL b2b_count got %0d want 5", got);
    else passed++;
    checks++;
    if (!dropped) $display("FAIL b2b_backpressure got ready=1 always want drop");
    else passed++;
    checks++;
    if (bad_hold) $display("FAIL b2b_hold got changed outputs want stable");
    else passed++;
    checks++;
    if (bus.sat_cnt !== 16'd2)
      $display("FAIL b2b_sat got %0d want 2", bus.sat_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit leak = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 7'h3F; bus.x2 = 7'h3F; bus.k1 = 3'd1; bus.k2 = 3'd1;
    bus.corr_en = 1'b1;
    step();
    bus.x1 = 7'h40; bus.x2 = 7'h40;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({bus.out_valid, bus.carry, bus.fractional, bus.char_sum} !== 13'd0)
      $display("FAIL rstmid_outs got %b/%b/%h/%h want 0/0/00/0",
               bus.out_valid, bus.carry, bus.fractional, bus.char_sum);
    else passed++;
    checks++;
    if (bus.sat_cnt !== 16'd0)
      $display("FAIL rstmid_sat got %0d want 0", bus.sat_cnt);
    else passed++;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rstmid_ready got %b want 1", bus.in_ready);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid !== 1'b0) leak = 1;
    end
    checks++;
    if (leak) $display("FAIL rstmid_stale got out_valid=1 want 0");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_carry();
    test_corr();
    test_sat();
    test_char_max();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
